// File: rtl/rr_grant_sequencer_pkg.sv
// Shared definitions for the round-robin grant sequencer: FSM state encodings
// and default sizing constants.
package rr_grant_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_ID_W     = 2;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_grant_sequencer_pick.sv
// rr_pick: combinational rotating-priority picker. Scans req upward from ptr,
// wrapping modulo NUM_REQ, and reports the first set bit.
module rr_pick
  import rr_grant_sequencer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Moore round-robin arbiter sequencing grant / hold / one-cycle release.
// Optional forced release after MAX_HOLD cycles: define RR_GRANT_TIMEOUT_EN.
module rr_grant_sequencer
  import rr_grant_sequencer_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_W     = DEF_ID_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [NUM_REQ-1:0] iReq,
  input  logic               iDone,
  output logic [NUM_REQ-1:0] oGnt,
  output logic [ID_W-1:0]    oGntId,
  output logic               oBusy,
  output logic               oTimeout
);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            owner_req;
  logic            force_rel;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_pick (
    .req   (iReq),
    .ptr   (ptr),
    .found (found),
    .winner(winner)
  );

  assign owner_req = iReq[owner];
  assign next_ptr  = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign oGntId    = owner;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);

  logic [CNT_W-1:0] hold_cnt;

  // A done or a withdrawal on the limit cycle is an ordinary release, not a timeout.
  assign force_rel = (hold_cnt == CNT_W'(MAX_HOLD - 1)) && !iDone && owner_req;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hold_cnt <= '0;
      oTimeout <= 1'b0;
    end else begin
      oTimeout <= (state == GRANT) && force_rel;
      if (state == GRANT) begin
        if (hold_cnt != CNT_W'(MAX_HOLD - 1)) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign force_rel = 1'b0;
  assign oTimeout  = 1'b0;
`endif

  // IDLE and RELEASE arbitrate identically; RELEASE already sees the advanced ptr.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      oGnt  <= '0;
      oBusy <= 1'b0;
    end else begin
      case (state)
        GRANT: begin
          if (iDone || !owner_req || force_rel) begin
            state <= RELEASE;
            ptr   <= next_ptr;
            oGnt  <= '0;
            oBusy <= 1'b0;
          end
        end
        default: begin
          if (found) begin
            state <= GRANT;
            owner <= winner;
            oGnt  <= NUM_REQ'(1'b1) << winner;
            oBusy <= 1'b1;
          end else begin
            state <= IDLE;
            oGnt  <= '0;
            oBusy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
